// File: rtl/pipeline_stage_buffer.sv
// Multi-stage valid/ready register pipeline. Each stage pairs a main register with a one-entry skid
// register, so no stage's ready depends on the stage below it in the same cycle.
module pipeline_stage_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 1,
  parameter int CNT_WIDTH  = $clog2(2*NUM_STAGES+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  busy_wait,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  localparam int LAST = NUM_STAGES - 1;

  logic                  hold;
  logic [NUM_STAGES-1:0] main_valid;
  logic [NUM_STAGES-1:0] skid_valid;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] arrive;
  logic [NUM_STAGES-1:0] take;
  logic [DATA_WIDTH-1:0] main_data [NUM_STAGES];

  // A flush or a stall blocks every handshake, both upstream and downstream.
  assign hold = busy_wait | flush;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic                  up_valid;
    logic [DATA_WIDTH-1:0] up_data;
    logic                  down_ready;
    logic                  main_valid_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [DATA_WIDTH-1:0] skid_data_q;

    if (s == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_chain
      assign up_valid = main_valid[s-1];
      assign up_data  = main_data[s-1];
    end

    if (s == LAST) begin : g_tail
      assign down_ready = out_ready & ~hold;
    end else begin : g_inner
      assign down_ready = stage_ready[s+1];
    end

    // Ready depends only on this stage's own skid register, so it never ripples combinationally.
    assign stage_ready[s] = ~skid_valid_q & ~hold;
    assign arrive[s]      = up_valid & stage_ready[s];
    assign take[s]        = main_valid_q & down_ready;

    assign main_valid[s] = main_valid_q;
    assign skid_valid[s] = skid_valid_q;
    assign main_data[s]  = main_data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every stage samples the
    // pre-edge values of its neighbours no matter in which order the simulator runs the blocks.
    always_ff @(posedge clk) begin
      // NOTE: the data registers are reset along with the valid bits, so out_data is never X.
      if (reset || flush) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
        main_data_q  <= '0;
        skid_data_q  <= '0;
      end else if (!busy_wait) begin
        if (take[s]) begin
          if (skid_valid_q) begin
            main_data_q  <= skid_data_q;
            skid_valid_q <= 1'b0;
          end else begin
            main_valid_q <= arrive[s];
            if (arrive[s]) main_data_q <= up_data;
          end
        end else if (!main_valid_q) begin
          if (arrive[s]) begin
            main_valid_q <= 1'b1;
            main_data_q  <= up_data;
          end
        end else if (arrive[s]) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= up_data;
        end
      end
    end
  end

  // Moves between stages conserve the entry count, so only the two boundary handshakes change it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (!busy_wait) begin
      occupancy <= occupancy + CNT_WIDTH'(arrive[0]) - CNT_WIDTH'(take[LAST]);
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = main_valid[LAST];
  assign out_data  = main_data[LAST];

endmodule
